uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART transmitter among NREQ requesters using round-robin arbitration.
//   Latches the granted byte, drives the transmitter's start and data inputs for one full
//   frame, then enforces an idle gap before the next frame.
//   Sits between client logic and the transmitter; requesters never touch the transmitter directly.
// PARAMETERS
//   NREQ          3    number of requesters, 2..8
//   FRAME_BITS    10   bits per frame (start + 8 data + stop); matches transmitter bit counter
//   CLKS_PER_BIT  1    clocks per transmitted bit
//   GAP_CYCLES    2    idle cycles with o_Txstart low between frames, >=1
// PORTS
//   i_clk        in   1         system clock, rising edge
//   i_reset      in   1         asynchronous, active-low reset
//   i_req        in   NREQ      per-requester request level; held with data until granted
//   i_data       in   8*NREQ    requester k byte at [8k+7:8k]
//   o_grant      out  NREQ      one-hot, 1-cycle pulse: requester k's byte accepted
//   o_Txstart    out  1         to transmitter i_Txstart
//   o_datain     out  8         to transmitter i_datain; stable for whole frame
//   o_busy       out  1         high in SEND and GAP
//   o_owner      out  3         index of last granted requester
// BEHAVIOUR
//   All outputs are registered.
//   Reset (async, i_reset=0): state=IDLE.
//     - o_grant=0, o_Txstart=0, o_datain=0, o_busy=0, o_owner=0.
//     - RR pointer = NREQ-1, so requester 0 has top priority first.
//     - A frame in progress is abandoned; no grant is replayed.
//   Let FC = FRAME_BITS*CLKS_PER_BIT.
//   States:
//     IDLE: at an edge with i_req!=0, select k = first set bit searching ptr+1, ptr+2, ...
//           (mod NREQ). At that same edge:
//           - o_grant[k]=1; o_datain=i_data[k]; o_Txstart=1; o_owner=k; ptr=k; o_busy=1
//           - state -> SEND
//           With no request: stay in IDLE.
//     SEND: o_Txstart held high for exactly FC cycles, counting the grant cycle.
//           Frame counter runs 0..FC-1. At terminal count: o_Txstart=0, state -> GAP.
//           i_req is ignored during SEND.
//     GAP:  o_Txstart low for GAP_CYCLES cycles.
//           At the last GAP edge: if i_req!=0, arbitrate and grant exactly as in IDLE
//           (straight to SEND); else -> IDLE with o_busy=0.
//   Timing: grant at edge t -> o_Txstart high over edges t..t+FC-1, low from t+FC;
//     earliest next grant at edge t+FC+GAP_CYCLES (defaults: 12-cycle frame period).
//   o_grant never has more than one bit set.
//   o_grant is never asserted outside the IDLE grant edge or the last GAP edge.
//   o_datain changes only on a grant edge.
//   A requester dropping i_req before its grant is legal; it loses its turn, no side effect.
//   Pointer wrap: after k=NREQ-1, search starts at 0.
//   Counter widths: $clog2(FC+1) and $clog2(GAP_CYCLES+1).
// STRUCTURE
//   uart_defs.vh (shared include):
//     - FRAME_BITS default
//     - state encodings S_IDLE=2'd0, S_SEND=2'd1, S_GAP=2'd2
//   Sub-module rr_arbiter: combinational. Inputs req and ptr; outputs one-hot gnt, index,
//     any. Reused by future RX-side schedulers.
//   Top level holds the FSM, frame/gap counters, data register and pointer.
// TESTING
//   1. Reset, then i_req=3'b001, data0=8'h58 ->
//      grant[0] pulse one cycle; o_datain=8'h58; o_Txstart high exactly 10 cycles.
//   2. i_req=3'b110 simultaneously after reset ->
//      requester 1 first, then requester 2 after 12 cycles; o_owner=1 then 2.
//   3. All three requesting continuously for 6 frames ->
//      grant order 0,1,2,0,1,2; 12-cycle period; o_grant always one-hot.
//   4. Assert i_reset=0 at frame cycle 5 ->
//      outputs 0 immediately (async); after release, requester 0 wins the next grant.
//   5. Requester 2 raises i_req during SEND of requester 1, then drops it before the GAP end ->
//      no grant[2]; state returns to IDLE.
//   6. Requester 0 alone, back-to-back bytes 8'hA5, 8'h3C ->
//      two frames; o_Txstart low exactly 2 cycles between them.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_pkg
//   Shared definitions for the UART transmit scheduler and its arbiter:
//   the default frame length and the scheduler state encoding.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

  // Start + 8 data + stop; must agree with the transmitter's bit counter.
  localparam int FRAME_BITS_DEF = 10;

  // Widest owner/pointer index; covers NREQ up to 8.
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

endpackage : uart_tx_scheduler_pkg

// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
//   Bundles the requester-facing and transmitter-facing signals of the
//   scheduler.
//   master : client side (drives i_req/i_data, observes the rest)
//   slave  : scheduler side (observes i_req/i_data, drives the rest)
//   Signals:
//     i_req     NREQ     per-requester request level
//     i_data    8*NREQ   requester k byte at [8k+7:8k]
//     o_grant   NREQ     one-hot acceptance pulse
//     o_Txstart 1        transmitter start
//     o_datain  8        transmitter data, stable for a whole frame
//     o_busy    1        frame or idle gap in progress
//     o_owner   3        index of last granted requester
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   i_req;
  logic [8*NREQ-1:0] i_data;
  logic [NREQ-1:0]   o_grant;
  logic              o_Txstart;
  logic [7:0]        o_datain;
  logic              o_busy;
  logic [2:0]        o_owner;

  modport master (
    output i_req, i_data,
    input  o_grant, o_Txstart, o_datain, o_busy, o_owner
  );

  modport slave (
    input  i_req, i_data,
    output o_grant, o_Txstart, o_datain, o_busy, o_owner
  );
endinterface : uart_tx_scheduler_if

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Searches ptr+1, ptr+2, ... (mod NREQ)
//   and picks the first active request.
//   Ports:
//     req_i    NREQ  request vector
//     ptr_i    3     index of the previous winner
//     gnt_o    NREQ  one-hot winner (all zero when nothing requests)
//     index_o  3     winner index
//     any_o    1     at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  logic found;

  // Two ascending passes give the circular order: first the indices above
  // the pointer, then wrap around to 0..ptr.
  always_comb begin
    gnt_o   = '0;
    index_o = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_i[j] && (IDX_W'(j) > ptr_i)) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        index_o  = IDX_W'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_i[j] && (IDX_W'(j) <= ptr_i)) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        index_o  = IDX_W'(j);
      end
    end
  end

  assign any_o = found;

endmodule : rr_arbiter

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART transmitter among NREQ requesters. A granted byte is
//   latched and presented with o_Txstart high for one full frame, followed
//   by an idle gap before the next grant.
//   Ports:
//     i_clk    system clock, rising edge
//     i_reset  asynchronous, active-low reset
//     bus      uart_tx_scheduler_if.slave (requests, data, grant, tx outputs)
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int FC  = FRAME_BITS * CLKS_PER_BIT;
  localparam int FCW = $clog2(FC + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  state_e            state_q;
  logic [FCW-1:0]    frameCnt_q;
  logic [FCW-1:0]    frameCnt_d;
  logic [GW-1:0]     gapCnt_q;
  logic [GW-1:0]     gapCnt_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [NREQ-1:0]   grant_q;
  logic              txStart_q;
  logic [7:0]        datain_q;
  logic              busy_q;
  logic [IDX_W-1:0]  owner_q;

  logic [NREQ-1:0]   arbGnt;
  logic [IDX_W-1:0]  arbIdx;
  logic              arbAny;
  logic [7:0]        arbData;
  logic              frameLast;
  logic              gapLast;
  logic              grantNow;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arbGnt),
    .index_o (arbIdx),
    .any_o   (arbAny)
  );

  // Byte of the arbitration winner.
  always_comb begin
    arbData = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arbIdx == IDX_W'(k)) arbData = bus.i_data[8*k +: 8];
    end
  end

  assign frameCnt_d = frameCnt_q + FCW'(1);
  assign gapCnt_d   = gapCnt_q + GW'(1);
  assign frameLast  = (frameCnt_q == FCW'(FC - 1));
  assign gapLast    = (gapCnt_q == GW'(GAP_CYCLES - 1));

  // The last gap edge grants exactly like IDLE, so back-to-back frames keep
  // a fixed FC+GAP_CYCLES period without passing through IDLE.
  assign grantNow = arbAny && ((state_q == S_IDLE) || (state_q == S_GAP && gapLast));

  // Scheduler FSM. The grant cycle is frame cycle 0, so o_Txstart stays high
  // for exactly FC cycles and drops at the edge where the count is FC-1.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      frameCnt_q <= '0;
      gapCnt_q   <= '0;
      ptr_q      <= IDX_W'(NREQ - 1);
      grant_q    <= '0;
      txStart_q  <= 1'b0;
      datain_q   <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
    end else begin
      grant_q <= '0;
      if (grantNow) begin
        grant_q    <= arbGnt;
        datain_q   <= arbData;
        txStart_q  <= 1'b1;
        owner_q    <= arbIdx;
        ptr_q      <= arbIdx;
        busy_q     <= 1'b1;
        frameCnt_q <= '0;
        state_q    <= S_SEND;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SEND: begin
            if (frameLast) begin
              txStart_q <= 1'b0;
              gapCnt_q  <= '0;
              state_q   <= S_GAP;
            end else begin
              frameCnt_q <= frameCnt_d;
            end
          end
          S_GAP: begin
            if (gapLast) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gapCnt_q <= gapCnt_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_grant   = grant_q;
  assign bus.o_Txstart = txStart_q;
  assign bus.o_datain  = datain_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_owner   = owner_q;

endmodule : uart_tx_scheduler

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//   Directed self-checking bench for uart_tx_scheduler with NREQ=3,
//   FRAME_BITS=10, CLKS_PER_BIT=1, GAP_CYCLES=2 (12-cycle frame period).
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic clk;
  logic rstN;
  logic monitorOn;
  int   checks;
  int   failures;

  uart_tx_scheduler_if #(.NREQ(3)) bus ();

  uart_tx_scheduler #(
    .NREQ         (3),
    .FRAME_BITS   (10),
    .CLKS_PER_BIT (1),
    .GAP_CYCLES   (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rstN),
    .bus     (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h time=%0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic [23:0] data);
    bus.i_req  = req;
    bus.i_data = data;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check the reset state, release mid-cycle.
  task automatic doReset();
    applyStimulus(3'b000, 24'h0);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant",   32'(bus.o_grant),   32'h0);
    checkOutput("rst_txstart", 32'(bus.o_Txstart), 32'h0);
    checkOutput("rst_datain",  32'(bus.o_datain),  32'h0);
    checkOutput("rst_busy",    32'(bus.o_busy),    32'h0);
    checkOutput("rst_owner",   32'(bus.o_owner),   32'h0);
    @(negedge clk);
    rstN = 1'b1;
    step();
  endtask

  // o_grant must never carry more than one bit.
  always @(negedge clk) begin
    if (monitorOn && rstN)
      checkOutput("grant_onehot", 32'($onehot0(bus.o_grant)), 32'h1);
  end

  // Hard time limit in case the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int highCnt;
    int lowCnt;
    logic [2:0] sawGrant;
    logic [7:0] bytes [3];
    int k;

    checks    = 0;
    failures  = 0;
    monitorOn = 1'b0;
    rstN      = 1'b0;
    applyStimulus(3'b000, 24'h0);
    monitorOn = 1'b1;

    // 1: single request, frame length
    $display("[TB] single request");
    doReset();
    applyStimulus(3'b001, 24'h00_00_58);
    step();
    checkOutput("t1_grant",   32'(bus.o_grant),   32'h1);
    checkOutput("t1_datain",  32'(bus.o_datain),  32'h58);
    checkOutput("t1_txstart", 32'(bus.o_Txstart), 32'h1);
    checkOutput("t1_busy",    32'(bus.o_busy),    32'h1);
    checkOutput("t1_owner",   32'(bus.o_owner),   32'h0);
    applyStimulus(3'b000, 24'h00_00_58);
    highCnt = 1;
    step();
    checkOutput("t1_grant_pulse", 32'(bus.o_grant), 32'h0);
    while (bus.o_Txstart && highCnt < 40) begin
      highCnt++;
      step();
    end
    checkOutput("t1_txstart_len", 32'(highCnt), 32'd10);
    checkOutput("t1_busy_gap0", 32'(bus.o_busy), 32'h1);
    step();
    checkOutput("t1_busy_gap1", 32'(bus.o_busy), 32'h1);
    step();
    checkOutput("t1_busy_idle", 32'(bus.o_busy), 32'h0);

    // 2: simultaneous requests 1 and 2
    $display("[TB] simultaneous requests");
    doReset();
    applyStimulus(3'b110, 24'h22_11_00);
    step();
    checkOutput("t2_grant1",  32'(bus.o_grant),  32'h2);
    checkOutput("t2_owner1",  32'(bus.o_owner),  32'h1);
    checkOutput("t2_datain1", 32'(bus.o_datain), 32'h11);
    applyStimulus(3'b100, 24'h22_11_00);
    repeat (11) step();
    checkOutput("t2_no_early", 32'(bus.o_grant), 32'h0);
    step();
    checkOutput("t2_grant2",  32'(bus.o_grant),  32'h4);
    checkOutput("t2_owner2",  32'(bus.o_owner),  32'h2);
    checkOutput("t2_datain2", 32'(bus.o_datain), 32'h22);
    applyStimulus(3'b000, 24'h0);

    // 3: all requesting for six frames
    $display("[TB] continuous round robin");
    bytes[0] = 8'hA0;
    bytes[1] = 8'hB1;
    bytes[2] = 8'hC2;
    doReset();
    applyStimulus(3'b111, 24'hC2_B1_A0);
    step();
    for (int f = 0; f < 6; f++) begin
      k = f % 3;
      checkOutput("t3_grant",  32'(bus.o_grant),  32'(3'b001 << k));
      checkOutput("t3_owner",  32'(bus.o_owner),  32'(k));
      checkOutput("t3_datain", 32'(bus.o_datain), 32'(bytes[k]));
      if (f < 5) begin
        repeat (11) step();
        checkOutput("t3_period", 32'(bus.o_grant), 32'h0);
        step();
      end
    end
    applyStimulus(3'b000, 24'h0);

    // 4: async reset mid-frame, pointer restarts at requester 0
    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(3'b001, 24'h00_22_11);
    step();
    checkOutput("t4_grant0", 32'(bus.o_grant), 32'h1);
    applyStimulus(3'b000, 24'h00_22_11);
    repeat (5) step();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t4_async_txstart", 32'(bus.o_Txstart), 32'h0);
    checkOutput("t4_async_busy",    32'(bus.o_busy),    32'h0);
    checkOutput("t4_async_datain",  32'(bus.o_datain),  32'h0);
    checkOutput("t4_async_owner",   32'(bus.o_owner),   32'h0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(3'b011, 24'h00_22_11);
    step();
    checkOutput("t4_regrant", 32'(bus.o_grant), 32'h1);
    checkOutput("t4_owner",   32'(bus.o_owner), 32'h0);
    applyStimulus(3'b000, 24'h0);

    // 5: request raised in SEND and dropped before gap end
    $display("[TB] withdrawn request");
    doReset();
    applyStimulus(3'b010, 24'h00_33_00);
    step();
    checkOutput("t5_grant1",  32'(bus.o_grant),  32'h2);
    checkOutput("t5_datain1", 32'(bus.o_datain), 32'h33);
    applyStimulus(3'b000, 24'h44_00_00);
    sawGrant = 3'b000;
    repeat (3) begin
      step();
      sawGrant |= bus.o_grant;
    end
    applyStimulus(3'b100, 24'h44_00_00);
    repeat (4) begin
      step();
      sawGrant |= bus.o_grant;
    end
    applyStimulus(3'b000, 24'h44_00_00);
    repeat (5) begin
      step();
      sawGrant |= bus.o_grant;
    end
    checkOutput("t5_no_grant", 32'(sawGrant),    32'h0);
    checkOutput("t5_idle",     32'(bus.o_busy),  32'h0);
    step();
    checkOutput("t5_still_idle", 32'(bus.o_busy),    32'h0);
    checkOutput("t5_txstart",    32'(bus.o_Txstart), 32'h0);
    checkOutput("t5_datain_hold", 32'(bus.o_datain), 32'h33);

    // 6: back-to-back bytes from requester 0
    $display("[TB] back-to-back frames");
    doReset();
    applyStimulus(3'b001, 24'h00_00_A5);
    step();
    checkOutput("t6_grant_a",  32'(bus.o_grant),  32'h1);
    checkOutput("t6_datain_a", 32'(bus.o_datain), 32'hA5);
    applyStimulus(3'b001, 24'h00_00_3C);
    highCnt = 1;
    step();
    while (bus.o_Txstart && highCnt < 40) begin
      highCnt++;
      step();
    end
    checkOutput("t6_frame_len",   32'(highCnt),      32'd10);
    checkOutput("t6_datain_hold", 32'(bus.o_datain), 32'hA5);
    lowCnt = 0;
    while (!bus.o_Txstart && lowCnt < 40) begin
      lowCnt++;
      step();
    end
    checkOutput("t6_gap_len",  32'(lowCnt),       32'd2);
    checkOutput("t6_grant_b",  32'(bus.o_grant),  32'h1);
    checkOutput("t6_datain_b", 32'(bus.o_datain), 32'h3C);
    applyStimulus(3'b000, 24'h0);
    repeat (14) step();
    checkOutput("t6_final_idle", 32'(bus.o_busy), 32'h0);

    monitorOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_scheduler
